mem_align_ctrl: RTL and testbench

MEM_ALIGN_CTRL -- requirements
Module: mem_align_ctrl

---
 rtl/mem_align_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_align_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_align_ctrl
// Brief    : RV32I load/store alignment controller between a pipeline and a
//            word-wide memory port (lane shifting, extension, timeout).
// Revision : 1.0
// ============================================================================
module mem_align_ctrl #(
  parameter int width   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [width-1:0] req_addr,
  input  logic [width-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [width-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [width-1:0] mem_addr,
  output logic [3:0]       mem_byte_enable,
  output logic [width-1:0] mem_wdata,
  input  logic [width-1:0] mem_rdata,
  input  logic             mem_resp
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam int                 c_cnt_w    = 10;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_off;
  logic [2:0]         r_funct3;

  logic               w_accept;
  logic               w_illegal;
  logic [1:0]         w_off;
  logic [3:0]         w_be;
  logic [width-1:0]   w_shift_wdata;
  logic [width-1:0]   w_rd_shift;
  logic [width-1:0]   w_load_data;

  assign req_ready     = (r_state == S_IDLE);
  assign w_accept      = req_valid && req_ready;
  assign w_off         = req_addr[1:0];
  assign w_shift_wdata = req_wdata << {w_off, 3'b000};

  // Stores have no unsigned variants, so funct3[2] set on a store is illegal.
  always_comb begin
    w_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: w_illegal = 1'b0;
      3'b001, 3'b101: w_illegal = req_addr[0];
      3'b010:         w_illegal = (req_addr[1:0] != 2'b00);
      default:        w_illegal = 1'b1;
    endcase
    if (req_write && req_funct3[2]) begin
      w_illegal = 1'b1;
    end
  end

  always_comb begin
    w_be = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   w_be = 4'b0001 << w_off;
      2'b01:   w_be = 4'b0011 << w_off;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_rd_shift  = mem_rdata >> {r_off, 3'b000};
    w_load_data = w_rd_shift;
    case (r_funct3)
      3'b000:  w_load_data = {{(width-8){w_rd_shift[7]}},   w_rd_shift[7:0]};
      3'b100:  w_load_data = {{(width-8){1'b0}},            w_rd_shift[7:0]};
      3'b001:  w_load_data = {{(width-16){w_rd_shift[15]}}, w_rd_shift[15:0]};
      3'b101:  w_load_data = {{(width-16){1'b0}},           w_rd_shift[15:0]};
      default: w_load_data = w_rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_off           <= '0;
      r_funct3        <= '0;
      rsp_valid       <= 1'b0;
      rsp_err         <= 1'b0;
      rsp_rdata       <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_addr        <= '0;
      mem_byte_enable <= '0;
      mem_wdata       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off    <= w_off;
            r_funct3 <= req_funct3;
            if (w_illegal) begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_state         <= S_ACCESS;
              r_cnt           <= '0;
              mem_read        <= !req_write;
              mem_write       <= req_write;
              mem_addr        <= {req_addr[width-1:2], 2'b00};
              mem_byte_enable <= w_be;
              mem_wdata       <= req_write ? w_shift_wdata : '0;
            end
          end
        end
        S_ACCESS: begin
          // A completion on the timeout edge wins over the timeout.
          if (mem_resp || (r_cnt == c_cnt_last)) begin
            r_state         <= S_RESP;
            rsp_valid       <= 1'b1;
            rsp_err         <= !mem_resp;
            rsp_rdata       <= (mem_resp && mem_read) ? w_load_data : '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_addr        <= '0;
            mem_byte_enable <= '0;
            mem_wdata       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_align_ctrl
// Brief    : Scoreboard bench for mem_align_ctrl (TIMEOUT=4 instance).
// Revision : 1.0
// ============================================================================
module tb_mem_align_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          rsp_cnt = 0;
  logic [32:0] sb_q[$];
  logic [32:0] mon_e;

  mem_align_ctrl #(.width(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      rsp_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e[32]});
        chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
      end
    end
  end

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int resp_after,
                        input logic illegal, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int   n;
    logic err;
    err = illegal || (resp_after >= TO);
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb_q.push_back({err, err ? 32'h0 : exp_rdata});
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = ~wr;
    req_funct3 = 3'b111;
    req_addr   = ~addr;
    req_wdata  = ~wdata;
    chk("ready_busy", {31'd0, req_ready}, 32'd0);
    if (illegal) begin
      chk("err_no_mem", {30'd0, mem_read, mem_write}, 32'd0);
      chk("err_latency", {31'd0, rsp_valid}, 32'd1);
    end else begin
      chk("mem_read", {31'd0, mem_read}, {31'd0, !wr});
      chk("mem_write", {31'd0, mem_write}, {31'd0, wr});
      chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("mem_be", {28'd0, mem_byte_enable}, {28'd0, exp_be});
      chk("mem_wdata", mem_wdata, exp_wdata);
      for (int c = 0; c < TO; c++) begin
        if (c > 0)
          chk("strobe_hold", {26'd0, mem_read, mem_write, mem_byte_enable}, {26'd0, !wr, wr, exp_be});
        if (c == resp_after) begin
          mem_resp  = 1'b1;
          mem_rdata = rdata;
          @(negedge clk);
          mem_resp  = 1'b0;
          mem_rdata = $urandom;
          break;
        end
        @(negedge clk);
      end
      chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
      chk("strobes_dropped", {30'd0, mem_read, mem_write}, 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int rsp0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_be", {28'd0, mem_byte_enable}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    //     wr    f3      addr          wdata         rdata         ra ill exp_rdata     be       exp_wdata
    do_req(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0, 0, 32'h0,        4'b1000, 32'hAB00_0000);
    do_req(1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 0, 32'hFFFF_8001, 4'b1100, 32'h0);
    do_req(1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_1234, 1, 0, 32'h0000_8001, 4'b1100, 32'h0);
    do_req(1'b0, 3'b000, 32'h0000_2001, 32'h0,        32'h8001_1234, 0, 0, 32'h0000_0012, 4'b0010, 32'h0);
    do_req(1'b0, 3'b000, 32'h0000_2003, 32'h0,        32'h8001_1234, 0, 0, 32'hFFFF_FF80, 4'b1000, 32'h0);
    do_req(1'b0, 3'b100, 32'h0000_2003, 32'h0,        32'h8001_1234, 2, 0, 32'h0000_0080, 4'b1000, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_3002, 32'h0,        32'h0,         0, 1, 32'h0,        4'b0000, 32'h0);
    do_req(1'b0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,         0, 1, 32'h0,        4'b0000, 32'h0);
    do_req(1'b1, 3'b001, 32'h0000_3001, 32'h1234,     32'h0,         0, 1, 32'h0,        4'b0000, 32'h0);
    do_req(1'b1, 3'b100, 32'h0000_3000, 32'h12,       32'h0,         0, 1, 32'h0,        4'b0000, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 99, 0, 32'h0,       4'b1111, 32'h0);
    do_req(1'b0, 3'b010, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 3, 0, 32'hCAFE_F00D, 4'b1111, 32'h0);

    // mem_resp while idle must not produce a response
    mem_resp = 1'b1;
    @(negedge clk);
    chk("resp_ignored_idle", {31'd0, rsp_valid}, 32'd0);
    chk("resp_ignored_ready", {31'd0, req_ready}, 32'd1);
    mem_resp = 1'b0;
    @(negedge clk);

    // abort an access with an asynchronous reset pulse
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_pre_read", {31'd0, mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_read", {31'd0, mem_read}, 32'd0);
    chk("rst_async_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0, 0, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    do_req(1'b1, 3'b001, 32'h0000_5002, 32'h0000_BEEF, 32'h0, 2, 0, 32'h0, 4'b1100, 32'hBEEF_0000);

    // back-to-back with req_valid held: one accept every three cycles
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6004;
    acc = 0;
    rsp0 = rsp_cnt;
    for (int i = 0; i < 12; i++) begin
      mem_resp  = mem_read;
      mem_rdata = 32'h1234_5678;
      chk("b2b_ready", {31'd0, req_ready}, {31'd0, (i % 3) == 0});
      if ((i % 3) == 0) begin
        sb_q.push_back({1'b0, 32'h1234_5678});
        acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    mem_resp  = 1'b0;
    @(negedge clk);
    chk("b2b_rsp_count", rsp_cnt - rsp0, acc);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
